// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR filter: the control FSM
// state type, default parameter values and the accumulator width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int    DEF_DW        = 16;
    localparam int    DEF_CW        = 16;
    localparam int    DEF_N_TAP     = 100;
    localparam int    DEF_N_MUL     = 20;
    localparam int    DEF_SHIFT     = 15;
    localparam string DEF_COEF_FILE = "coeff.hex";

    // Wide enough to sum N_TAP full-precision products without overflow.
    function automatic int acc_width(input int dw, input int cw, input int n_tap);
        return dw + cw + $clog2(n_tap);
    endfunction

endpackage

// File: rtl/fir_mac_slice.sv
// -----------------------------------------------------------------------------
// fir_mac_slice
// One stage of the time-multiplexed FIR: N_MUL operand pairs are registered on
// 'load', multiplied at full precision and summed into a single ACC_W-bit
// signed partial sum that the top level adds into its accumulator one cycle
// after the load.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears operand registers)
//   load   in   capture x_op / c_op into the operand registers
//   x_op   in   N_MUL signed samples for this stage
//   c_op   in   N_MUL signed coefficients for this stage
//   sum    out  signed sum of the N_MUL registered products
// -----------------------------------------------------------------------------
module fir_mac_slice #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int N_MUL = 20,
    parameter int ACC_W = 39
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic signed [DW-1:0]    x_op [N_MUL],
    input  logic signed [CW-1:0]    c_op [N_MUL],
    output logic signed [ACC_W-1:0] sum
);

    localparam int PW = DW + CW;

    logic signed [DW-1:0] x_q [N_MUL];
    logic signed [CW-1:0] c_q [N_MUL];
    logic signed [PW-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MUL; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_MUL; i++) begin
                x_q[i] <= x_op[i];
                c_q[i] <= c_op[i];
            end
        end
    end

    // Operands are sign-extended to the product width before multiplying so
    // nothing is lost in a self-determined 16x16 multiply.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int i = 0; i < N_MUL; i++) begin
            prod = PW'(x_q[i]) * PW'(c_q[i]);
            sum  = sum + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_tdm_param.sv
// -----------------------------------------------------------------------------
// fir_tdm_param
// Time-multiplexed N_TAP FIR filter using N_MUL multipliers. A sample is
// accepted in IDLE, the taps are processed N_MUL at a time over S = N_TAP/N_MUL
// stages, and the accumulated result is shifted right by SHIFT and presented
// on y_out with a one-cycle out_valid strobe S+2 cycles after acceptance.
//
// Build option: define FIR_SAT_EN to saturate the shifted result to the DW-bit
// signed range; otherwise the low DW bits are kept (wrap-around).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   x_in valid
//   in_ready   out  high in IDLE, block can accept a sample
//   x_in       in   DW-bit signed input sample
//   out_valid  out  one-cycle strobe, y_out valid
//   y_out      out  DW-bit filtered sample, held until the next result
//   coef_we    in   coefficient write strobe (honoured in IDLE only)
//   coef_addr  in   coefficient index
//   coef_data  in   CW-bit signed coefficient value
// -----------------------------------------------------------------------------
module fir_tdm_param
    import fir_pkg::*;
#(
    parameter int    DW        = DEF_DW,
    parameter int    CW        = DEF_CW,
    parameter int    N_TAP     = DEF_N_TAP,
    parameter int    N_MUL     = DEF_N_MUL,
    parameter int    SHIFT     = DEF_SHIFT,
    parameter string COEF_FILE = DEF_COEF_FILE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              x_in,
    output logic                       out_valid,
    output logic [DW-1:0]              y_out,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAP)-1:0]   coef_addr,
    input  logic [CW-1:0]              coef_data
);

    localparam int S     = N_TAP / N_MUL;
    localparam int ACC_W = acc_width(DW, CW, N_TAP);
    localparam int AW    = $clog2(N_TAP);
    localparam int SW    = $clog2(S + 1);

    fir_state_t state, state_next;

    logic signed [DW-1:0]    x_line [N_TAP];
    logic signed [CW-1:0]    coef   [N_TAP];
    logic signed [DW-1:0]    x_op   [N_MUL];
    logic signed [CW-1:0]    c_op   [N_MUL];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mac_sum;
    logic [SW-1:0]           stage;
    logic                    accept;
    logic                    load;
    logic                    addr_ok;
    logic                    wr_direct;
    logic                    wr_defer;
    logic                    pend_valid;
    logic [AW-1:0]           pend_addr;
    logic [CW-1:0]           pend_data;
    logic [DW-1:0]           y_next;
    int                      base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // MAC runs S+1 cycles: S operand loads, the last of which is accumulated
    // in the extra cycle while stage sits at S.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (stage == SW'(S)) state_next = OUT;
                else                 load       = 1'b1;
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        base = 0;
        if (stage < SW'(S)) base = int'(stage) * N_MUL;
        for (int i = 0; i < N_MUL; i++) begin
            x_op[i] = x_line[AW'(base + i)];
            c_op[i] = coef[AW'(base + i)];
        end
    end

    fir_mac_slice #(
        .DW    (DW),
        .CW    (CW),
        .N_MUL (N_MUL),
        .ACC_W (ACC_W)
    ) u_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .x_op  (x_op),
        .c_op  (c_op),
        .sum   (mac_sum)
    );

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clamped;

    always_comb begin
        shifted = acc >>> SHIFT;
        clamped = shifted;
        if (shifted > SAT_MAX)      clamped = SAT_MAX;
        else if (shifted < SAT_MIN) clamped = SAT_MIN;
        y_next = DW'(clamped);
    end
`else
    always_comb begin
        y_next = DW'(acc >>> SHIFT);
    end
`endif

    // A write arriving on the same edge as an accept must not change the
    // sample now being filtered, so it is parked and committed in OUT.
    assign addr_ok   = (int'(coef_addr) < N_TAP);
    assign wr_direct = coef_we && addr_ok && (state == IDLE) && !in_valid;
    assign wr_defer  = coef_we && addr_ok && accept;

    always_ff @(posedge clk) begin
        if (wr_direct)
            coef[coef_addr] <= coef_data;
        else if (pend_valid && (state == OUT))
            coef[pend_addr] <= pend_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_TAP; k++) x_line[k] <= '0;
            acc        <= '0;
            stage      <= '0;
            y_out      <= '0;
            out_valid  <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                x_line[0] <= x_in;
                for (int k = 1; k < N_TAP; k++) x_line[k] <= x_line[k-1];
                acc   <= '0;
                stage <= '0;
            end
            if (state == MAC) begin
                if (stage != '0)     acc   <= acc + mac_sum;
                if (stage != SW'(S)) stage <= stage + SW'(1);
            end
            if (state == OUT) begin
                y_out     <= y_next;
                out_valid <= 1'b1;
            end
            if (wr_defer) begin
                pend_valid <= 1'b1;
                pend_addr  <= coef_addr;
                pend_data  <= coef_data;
            end else if (state == OUT) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_param.sv
// -----------------------------------------------------------------------------
// tb_fir_tdm_param
// Scoreboard bench for fir_tdm_param at default parameters. Stimulus pushes the
// expected result and the cycle it must appear on; a monitor pops and compares
// on every out_valid. Define FIR_SAT_EN for both bench and RTL to select the
// saturating expectations.
// -----------------------------------------------------------------------------
module tb_fir_tdm_param;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int N_TAP = 100;
    localparam int N_MUL = 20;
    localparam int SHIFT = 15;
    localparam int AW    = 7;
    localparam int LAT   = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in;
    logic          out_valid;
    logic [DW-1:0] y_out;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   t;
    int   prev;

    fir_tdm_param #(
        .DW    (DW),
        .CW    (CW),
        .N_TAP (N_TAP),
        .N_MUL (N_MUL),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .y_out     (y_out),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Expected output after k consecutive 0x7FFF samples with all taps 0x7FFF.
    function automatic logic [DW-1:0] fill_exp(input int k);
        longint v;
        v = (longint'(k) * 64'sd1073676289) >>> 15;
`ifdef FIR_SAT_EN
        if (v > 32767) v = 32767;
`endif
        return v[DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out: y_out=%0d at cycle %0d, nothing expected", y_out, cycle);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("y_out", 32'(y_out), 32'(mon_e.data));
                checkOutput("out_cycle", 32'(cycle), 32'(mon_e.due));
            end
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] expv,
                                 input bit expect_out, input bit hold,
                                 input bit we, input logic [CW-1:0] wdata,
                                 output int acc_cycle);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        if (we) begin
            coef_we   = 1'b1;
            coef_addr = '0;
            coef_data = wdata;
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%b, required 1 within 40 cycles", in_ready);
            in_valid  = 1'b0;
            coef_we   = 1'b0;
            acc_cycle = -1;
            return;
        end
        @(negedge clk);
        acc_cycle = cycle;
        if (!hold) in_valid = 1'b0;
        coef_we = 1'b0;
        if (expect_out) sb.push_back(exp_t'{expv, cycle + LAT});
    endtask

    task automatic write_coef(input logic [AW-1:0] addr, input logic [CW-1:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_y_out", 32'(y_out), 32'd0);
        rst_n = 1'b1;

        $display("[TB] impulse response");
        for (int k = 0; k < N_TAP; k++) write_coef(AW'(k), CW'(2 * (k + 1)));
        applyStimulus(16'd16384, 16'd1, 1'b1, 1'b0, 1'b0, '0, t);
        for (int n = 1; n <= N_TAP; n++)
            applyStimulus(16'd0, (n < N_TAP) ? DW'(n + 1) : 16'd0, 1'b1, 1'b0, 1'b0, '0, t);
        wait_drain();

        $display("[TB] back-to-back timing");
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'd0, 16'd0, 1'b1, 1'b1, 1'b0, '0, t);
            if (i > 0) checkOutput("accept_interval", 32'(t - prev), 32'd8);
            prev = t;
        end
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] full-scale fill");
        for (int k = 0; k < N_TAP; k++) write_coef(AW'(k), 16'h7FFF);
        for (int k = 1; k <= N_TAP; k++) begin
            if (k == N_TAP)
`ifdef FIR_SAT_EN
                applyStimulus(16'h7FFF, 16'd32767, 1'b1, 1'b0, 1'b0, '0, t);
`else
                applyStimulus(16'h7FFF, 16'hFF38, 1'b1, 1'b0, 1'b0, '0, t);
`endif
            else
                applyStimulus(16'h7FFF, fill_exp(k), 1'b1, 1'b0, 1'b0, '0, t);
        end
        wait_drain();

        $display("[TB] reset during MAC");
        applyStimulus(16'h1234, 16'd0, 1'b0, 1'b0, 1'b0, '0, t);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_y_out", 32'(y_out), 32'd0);
        checkOutput("rst_async_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (12) @(negedge clk);
        checkOutput("rst_y_out_held", 32'(y_out), 32'd0);

        $display("[TB] coefficient writes");
        write_coef(7'd0, 16'h2000);
        applyStimulus(16'd0, 16'd0, 1'b1, 1'b0, 1'b0, '0, t);
        write_coef(7'd0, 16'h4000);
        wait_drain();
        applyStimulus(16'h7FFF, 16'h1FFF, 1'b1, 1'b0, 1'b1, 16'h4000, t);
        wait_drain();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h7FFF, 16'h3FFF, 1'b1, 1'b0, 1'b0, '0, t);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_tdm_param.md
FIR_TDM_PARAM -- requirements
Module: fir_tdm_param

Interface
REQ-001 SHALL have parameter DW, default 16, sample width (signed).
REQ-002 SHALL have parameter CW, default 16, coefficient width (signed).
REQ-003 SHALL have parameter N_TAP, default 100, filter length.
REQ-004 SHALL have parameter N_MUL, default 20, parallel multipliers; N_TAP multiple of N_MUL.
REQ-005 SHALL have parameter SHIFT, default 15, output arithmetic right shift.
REQ-006 SHALL have parameter COEF_FILE, default "coeff.hex", initial coefficient image.
REQ-007 SHALL have port clk  in  1  clock, rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port in_valid  in  1  x_in valid.
REQ-010 SHALL have port in_ready  out  1  block can accept a sample.
REQ-011 SHALL have port x_in  in  DW  input sample.
REQ-012 SHALL have port out_valid  out  1  one-cycle strobe, y_out valid.
REQ-013 SHALL have port y_out  out  DW  filtered sample, held until next result.
REQ-014 SHALL have port coef_we  in  1  coefficient write strobe.
REQ-015 SHALL have port coef_addr  in  clog2(N_TAP)  coefficient index.
REQ-016 SHALL have port coef_data  in  CW  coefficient value.

Function
REQ-017 SHALL use S = N_TAP/N_MUL and ACC_W = DW+CW+clog2(N_TAP).
REQ-018 SHALL use FSM states IDLE, MAC, OUT; in_ready = 1 only in IDLE.
REQ-019 SHALL accept a sample on an edge with in_valid and in_ready: x[0]<=x_in, x[k]<=x[k-1] for k=1..N_TAP-1, acc<=0, stage<=0, IDLE->MAC.
REQ-020 SHALL register operands x[stage*N_MUL+i], c[stage*N_MUL+i] for stage 0..S-1 in MAC, one stage per cycle.
REQ-021 SHALL add the sum of the N_MUL registered products of stage k-1 into acc one cycle after that stage is loaded; MAC lasts S+1 cycles, then moves to OUT.
REQ-022 SHALL compute y_out <= acc >>> SHIFT, reduced to DW bits per REQ-030/031, in OUT; out_valid high for that single cycle; OUT->IDLE.
REQ-023 SHALL assert out_valid exactly S+2 cycles after the accepting edge; throughput is one sample per S+3 cycles.
REQ-024 SHALL perform all arithmetic signed at full ACC_W precision, with no intermediate truncation.
REQ-025 SHALL write c[coef_addr] <= coef_data on coef_we only in IDLE; a write in MAC/OUT is ignored; coef_addr >= N_TAP is ignored.
REQ-026 SHALL give an accept the old coefficient when coef_we and accept occur on the same edge; the write takes effect from the next sample.
REQ-027 SHALL ignore in_valid outside IDLE, so the delay line is unchanged.

Reset
REQ-028 SHALL, on rst_n low, immediately clear state to IDLE, delay line, acc, operand regs, stage, y_out and out_valid to 0.
REQ-029 SHALL, on reset during MAC/OUT, abort with no out_valid; coefficients keep their values (not reset).

Configuration
REQ-030 SHALL, with FIR_SAT_EN defined, saturate the shifted result to [-2^(DW-1), 2^(DW-1)-1].
REQ-031 SHALL, without FIR_SAT_EN, take the low DW bits of the shifted result (wrap).

Structure
REQ-032 SHALL place the state enum, ACC_W computation and default parameter constants in package fir_pkg.
REQ-033 SHALL implement the N_MUL multipliers plus registered adder tree as sub-module fir_mac_slice.

Verification
REQ-034 SHALL cover impulse: c[k]=2(k+1), x=16384 then zeros -> y_out for sample n = n+1, n=0..99, then 0.
REQ-035 SHALL cover timing: in_valid held high (defaults) -> accept every 8 cycles, out_valid 7 cycles after each accept, single-cycle.
REQ-036 SHALL cover saturation: all c=0x7FFF, 100 samples of 0x7FFF -> y_out 32767 with FIR_SAT_EN; low 16 bits of (100*0x7FFF*0x7FFF)>>>15 without.
REQ-037 SHALL cover coefficient write: write c[0]=0x4000 during MAC -> ignored; in IDLE -> next impulse 0x7FFF yields y_out 0x3FFF.
REQ-038 SHALL cover reset: rst_n low 3 cycles into MAC -> no out_valid, y_out 0, in_ready 1 after release, next output uses cleared delay line.
